// File: rtl/mem_responder.sv
// mem_responder: instruction ROM and data RAM beside the CPU.
// Answers fetch, load and store requests with combinational reads.
// On end of execution it streams the whole RAM out over a valid/ready dump port.
module mem_responder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk_main,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_to_rom,
    input  logic              enable_to_rom,
    output logic [DATA_W-1:0] data_from_rom,
    input  logic [ADDR_W-1:0] address_to_ram,
    input  logic [DATA_W-1:0] data_to_ram,
    input  logic              write_enable_to_ram,
    input  logic              read_enable_to_ram,
    output logic [DATA_W-1:0] data_from_ram,
    input  logic              enable_ram_read,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
    logic              dump_valid_r, dump_valid_nxt_s;
    logic              dump_done_r, dump_done_nxt_s;
    logic              cnt_last_s;
    logic              in_idle_s;

    logic [DATA_W-1:0] rom_r [DEPTH];
    logic [DATA_W-1:0] ram_r [DEPTH];

    assign cnt_last_s = (cnt_r == {ADDR_W{1'b1}});
    assign in_idle_s  = (state_r == ST_IDLE);

    // Host ROM load; memory is not reset and only accepts writes while idle
    always_ff @(posedge clk_main) begin
        if (load_en && in_idle_s) begin
            rom_r[load_addr] <= load_data;
        end
    end

    // CPU store; frozen outside IDLE so the dump sees a stable image
    always_ff @(posedge clk_main) begin
        if (write_enable_to_ram && in_idle_s) begin
            ram_r[address_to_ram] <= data_to_ram;
        end
    end

    // Combinational fetch and load ports, zero when not enabled
    always_comb begin
        data_from_rom = {DATA_W{1'b0}};
        data_from_ram = {DATA_W{1'b0}};
        if (enable_to_rom) begin
            data_from_rom = rom_r[address_to_rom];
        end else begin
            data_from_rom = {DATA_W{1'b0}};
        end
        if (read_enable_to_ram) begin
            data_from_ram = ram_r[address_to_ram];
        end else begin
            data_from_ram = {DATA_W{1'b0}};
        end
    end

    // State, counter and dump flags register
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {ADDR_W{1'b0}};
            dump_valid_r <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            dump_valid_r <= dump_valid_nxt_s;
            dump_done_r  <= dump_done_nxt_s;
        end
    end

    // Next-state logic; flags are computed for the next state so they come straight from flops
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        dump_valid_nxt_s = dump_valid_r;
        dump_done_nxt_s  = dump_done_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_ram_read) begin
                    state_nxt_s      = ST_DUMP;
                    cnt_nxt_s        = {ADDR_W{1'b0}};
                    dump_valid_nxt_s = 1'b1;
                    dump_done_nxt_s  = 1'b0;
                end else begin
                    dump_valid_nxt_s = 1'b0;
                    dump_done_nxt_s  = 1'b0;
                end
            end
            ST_DUMP: begin
                if (dump_valid_r && dump_ready) begin
                    if (cnt_last_s) begin
                        // Terminal word leaves the state, so cnt never wraps here
                        state_nxt_s      = ST_DONE;
                        dump_valid_nxt_s = 1'b0;
                        dump_done_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    // Backpressure: hold address and data stable
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_DONE: begin
                if (!enable_ram_read) begin
                    state_nxt_s      = ST_IDLE;
                    cnt_nxt_s        = {ADDR_W{1'b0}};
                    dump_valid_nxt_s = 1'b0;
                    dump_done_nxt_s  = 1'b0;
                end else begin
                    dump_done_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                cnt_nxt_s        = {ADDR_W{1'b0}};
                dump_valid_nxt_s = 1'b0;
                dump_done_nxt_s  = 1'b0;
            end
        endcase
    end

    assign dump_valid = dump_valid_r;
    assign dump_done  = dump_done_r;
    assign dump_addr  = cnt_r;
    assign dump_data  = ram_r[cnt_r];

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

    logic        clk_main = 1'b0;
    logic        reset;
    logic [5:0]  address_to_rom;
    logic        enable_to_rom;
    logic [15:0] data_from_rom;
    logic [5:0]  address_to_ram;
    logic [15:0] data_to_ram;
    logic        write_enable_to_ram;
    logic        read_enable_to_ram;
    logic [15:0] data_from_ram;
    logic        enable_ram_read;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [15:0] load_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [5:0]  dump_addr;
    logic [15:0] dump_data;
    logic        dump_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] model [64];

    mem_responder #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk_main(clk_main), .reset(reset),
        .address_to_rom(address_to_rom), .enable_to_rom(enable_to_rom),
        .data_from_rom(data_from_rom),
        .address_to_ram(address_to_ram), .data_to_ram(data_to_ram),
        .write_enable_to_ram(write_enable_to_ram),
        .read_enable_to_ram(read_enable_to_ram), .data_from_ram(data_from_ram),
        .enable_ram_read(enable_ram_read),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk_main = ~clk_main;

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_addr !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_flags: valid=%b done=%b addr=%0d, want 0 0 0", dump_valid, dump_done, dump_addr);
        end
        n_cmp++;
        if (data_from_rom !== 16'h0000 || data_from_ram !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_reads: rom=%h ram=%h, want 0000 0000", data_from_rom, data_from_ram);
        end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_rom();
        load_en = 1'b1; load_addr = 6'd5; load_data = 16'hA123;
        tick();
        load_addr = 6'd63; load_data = 16'hBEEF;
        tick();
        load_en = 1'b0;
        address_to_rom = 6'd5; enable_to_rom = 1'b1;
        #1;
        n_cmp++;
        if (data_from_rom !== 16'hA123) begin
            n_bad++;
            $display("FAIL rom_read5: got %h want a123", data_from_rom);
        end
        address_to_rom = 6'd63;
        #1;
        n_cmp++;
        if (data_from_rom !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL rom_read63: got %h want beef", data_from_rom);
        end
        enable_to_rom = 1'b0;
        #1;
        n_cmp++;
        if (data_from_rom !== 16'h0000) begin
            n_bad++;
            $display("FAIL rom_disabled: got %h want 0000", data_from_rom);
        end
    endtask

    task automatic test_ram();
        write_enable_to_ram = 1'b1; address_to_ram = 6'd10; data_to_ram = 16'h00FF;
        tick();
        write_enable_to_ram = 1'b0; read_enable_to_ram = 1'b1;
        #1;
        n_cmp++;
        if (data_from_ram !== 16'h00FF) begin
            n_bad++;
            $display("FAIL ram_read10: got %h want 00ff", data_from_ram);
        end
        read_enable_to_ram = 1'b0;
        #1;
        n_cmp++;
        if (data_from_ram !== 16'h0000) begin
            n_bad++;
            $display("FAIL ram_disabled: got %h want 0000", data_from_ram);
        end
        // Host load and CPU store in the same cycle both land
        load_en = 1'b1; load_addr = 6'd7; load_data = 16'h1234;
        write_enable_to_ram = 1'b1; address_to_ram = 6'd7; data_to_ram = 16'h5678;
        tick();
        load_en = 1'b0; write_enable_to_ram = 1'b0;
        enable_to_rom = 1'b1; address_to_rom = 6'd7; read_enable_to_ram = 1'b1;
        #1;
        n_cmp++;
        if (data_from_rom !== 16'h1234 || data_from_ram !== 16'h5678) begin
            n_bad++;
            $display("FAIL same_cycle_writes: rom=%h ram=%h want 1234 5678", data_from_rom, data_from_ram);
        end
        enable_to_rom = 1'b0; read_enable_to_ram = 1'b0;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 64; i++) begin
            write_enable_to_ram = 1'b1; address_to_ram = 6'(i); data_to_ram = 16'(i * 3);
            model[i] = 16'(i * 3);
            tick();
        end
        write_enable_to_ram = 1'b0;
    endtask

    task automatic test_dump();
        int bad_words;
        fill_ram();
        n_cmp++;
        if (dump_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_valid: got %b want 0", dump_valid);
        end
        enable_ram_read = 1'b1;
        tick();
        enable_ram_read = 1'b0;
        dump_ready = 1'b1;
        bad_words = 0;
        for (int i = 0; i < 64; i++) begin
            if (dump_valid !== 1'b1 || dump_addr !== 6'(i) || dump_data !== model[i]) begin
                bad_words++;
                $display("FAIL dump_word: valid=%b addr=%0d data=%h want 1 %0d %h", dump_valid, dump_addr, dump_data, i, model[i]);
            end
            if (i == 5) begin
                write_enable_to_ram = 1'b1; address_to_ram = 6'd3; data_to_ram = 16'h1111;
            end
            tick();
            write_enable_to_ram = 1'b0;
        end
        n_cmp++;
        if (bad_words != 0) n_bad++;
        n_cmp++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dump_end: done=%b valid=%b want 1 0", dump_done, dump_valid);
        end
        tick();
        n_cmp++;
        if (dump_done !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_idle: done=%b want 0", dump_done);
        end
        read_enable_to_ram = 1'b1; address_to_ram = 6'd3;
        #1;
        n_cmp++;
        if (data_from_ram !== 16'h0009) begin
            n_bad++;
            $display("FAIL store_in_dump_ignored: got %h want 0009", data_from_ram);
        end
        read_enable_to_ram = 1'b0;
    endtask

    task automatic test_backpressure();
        int exp_addr;
        int cyc;
        int bad_words;
        enable_ram_read = 1'b1;
        tick();
        enable_ram_read = 1'b0;
        exp_addr = 0; cyc = 0; bad_words = 0;
        while (exp_addr < 64 && cyc < 300) begin
            dump_ready = (cyc % 3 != 1);
            #1;
            if (dump_valid !== 1'b1 || dump_addr !== 6'(exp_addr) || dump_data !== model[exp_addr]) begin
                bad_words++;
                $display("FAIL bp_word: valid=%b addr=%0d data=%h want 1 %0d %h", dump_valid, dump_addr, dump_data, exp_addr, model[exp_addr]);
            end
            if (dump_ready) exp_addr++;
            tick();
            cyc++;
        end
        n_cmp++;
        if (bad_words != 0 || exp_addr != 64) begin
            n_bad++;
            $display("FAIL bp_sequence: bad=%0d words=%0d want 0 64", bad_words, exp_addr);
        end
        n_cmp++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_end: done=%b valid=%b want 1 0", dump_done, dump_valid);
        end
        dump_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_dump();
        int bad_words;
        // Store on the dump-entry edge must be captured in the dump
        write_enable_to_ram = 1'b1; address_to_ram = 6'd0; data_to_ram = 16'hCAFE;
        enable_ram_read = 1'b1;
        tick();
        write_enable_to_ram = 1'b0; enable_ram_read = 1'b0;
        model[0] = 16'hCAFE;
        n_cmp++;
        if (dump_valid !== 1'b1 || dump_addr !== 6'd0 || dump_data !== 16'hCAFE) begin
            n_bad++;
            $display("FAIL entry_store: valid=%b addr=%0d data=%h want 1 0 cafe", dump_valid, dump_addr, dump_data);
        end
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (dump_addr !== 6'd20 || dump_data !== 16'd60) begin
            n_bad++;
            $display("FAIL word20: addr=%0d data=%h want 20 003c", dump_addr, dump_data);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_addr !== 6'd0) begin
            n_bad++;
            $display("FAIL mid_reset: valid=%b done=%b addr=%0d want 0 0 0", dump_valid, dump_done, dump_addr);
        end
        #1 reset = 1'b0;
        enable_ram_read = 1'b1;
        tick();
        enable_ram_read = 1'b0;
        bad_words = 0;
        for (int i = 0; i < 64; i++) begin
            if (dump_valid !== 1'b1 || dump_addr !== 6'(i) || dump_data !== model[i]) begin
                bad_words++;
                $display("FAIL restart_word: valid=%b addr=%0d data=%h want 1 %0d %h", dump_valid, dump_addr, dump_data, i, model[i]);
            end
            tick();
        end
        n_cmp++;
        if (bad_words != 0) n_bad++;
        n_cmp++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_end: done=%b valid=%b want 1 0", dump_done, dump_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        address_to_rom = 6'd0; enable_to_rom = 1'b0;
        address_to_ram = 6'd0; data_to_ram = 16'h0000;
        write_enable_to_ram = 1'b0; read_enable_to_ram = 1'b0;
        enable_ram_read = 1'b0;
        load_en = 1'b0; load_addr = 6'd0; load_data = 16'h0000;
        dump_ready = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 16'h0000;
        test_reset();
        test_rom();
        test_ram();
        test_dump();
        test_backpressure();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
